mul_operand_loader_tainttrack: RTL and testbench
================================================

Name: mul_operand_loader_tainttrack

Overview:
Upstream feeder for the taint-tracked multiplier. It assembles the multiplier and multiplicand from a narrow word stream with per-bit taint. It then issues a one-cycle start pulse with its taint and waits for productDone before accepting the next operand pair. Operand and taint registers drive the multiplier's multiplier/multiplicand ports directly.

Parameters:
WIDTH, 4096, operand width in bits; must equal the downstream multiplier WIDTH.
BUS_W, 64, input word width in bits; WIDTH % BUS_W == 0.
NWORDS, WIDTH/BUS_W (derived localparam), number of beats per operand; NWORDS >= 1.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  word-stream valid.
in_valid_t  input  1  taint of in_valid.
in_data  input  BUS_W  operand word, least-significant word first.
in_data_t  input  BUS_W  bitwise taint of in_data.
in_ready  output  1  loader accepts a word this cycle.
multiplier  output  WIDTH  assembled multiplier.
multiplier_t  output  WIDTH  bitwise taint of multiplier.
multiplicand  output  WIDTH  assembled multiplicand.
multiplicand_t  output  WIDTH  bitwise taint of multiplicand.
start  output  1  one-cycle start pulse to the multiplier.
start_t  output  1  taint of start.
productDone  input  1  multiplier completion flag (level, may stay high).
productDone_t  input  1  taint of productDone.
busy  output  1  high from the START cycle until productDone is seen.

Behaviour:
- The reset state is LOAD_MR. After reset: word counter 0, all operand and taint registers 0, start=0, start_t=0, busy=0, ctrl_taint=0.
- Accept condition: in_valid && in_ready. in_ready = 1 in LOAD_MR and LOAD_MD, and 0 in every other state.
- FSM states: LOAD_MR, LOAD_MD, START, ARM, WAIT.
- LOAD_MR: each accepted word is written to multiplier[cnt*BUS_W +: BUS_W] and its taint to the same slice of multiplier_t. cnt increments on each accept. When the accept occurs at cnt==NWORDS-1, cnt wraps to 0 and the FSM goes to LOAD_MD.
- LOAD_MD: same as LOAD_MR, but writes multiplicand/multiplicand_t. Accepting the last word goes to START.
- START: start=1 for exactly this cycle, start_t=ctrl_taint, busy=1. Always goes to ARM next.
- ARM: busy=1. productDone is ignored here so a stale done from the previous operation is not taken. Always goes to WAIT.
- WAIT: busy=1. When productDone==1, go to LOAD_MR and clear ctrl_taint.
- ctrl_taint (sticky): set when in_valid_t=1 in any cycle where in_ready=1, whether or not the word is accepted. Also set when productDone_t=1 in WAIT or ARM. Cleared only by reset or on the WAIT->LOAD_MR transition. The clear takes priority over a set in that same cycle.
- start_t is 0 in every cycle except START.
- Operand registers are not cleared between operations. They stay stable from the last accepted word until they are overwritten in the next LOAD phase.
- Words presented while in_ready=0 are not consumed; the source must hold them.
- Reset mid-operation in any state returns to the reset state in the next cycle and drops any partial load. start is never emitted during or straight out of reset.
- NWORDS==1: each LOAD state lasts exactly one accepted beat.
- Minimum latency from the first accepted word to start is 2*NWORDS cycles, with start in the cycle after the last accept.

Decomposition:
- Package mul_loader_pkg holds the state encoding localparams (LOAD_MR, LOAD_MD, START, ARM, WAIT; 3 bits) and a CNT_W = $clog2(NWORDS) helper (minimum 1).
- Sub-module mul_operand_slicereg_tainttrack (params WIDTH, BUS_W) is instantiated twice. It holds the value and taint registers, with write-enable, slice index, word and word taint inputs, and a synchronous clear on rst.
- The top level holds the FSM, cnt and ctrl_taint.

Test Plan (WIDTH=8, BUS_W=4, NWORDS=2):
- Basic load: words 0x3, 0xA, then 0x5, 0x1, all taints 0 -> multiplier=0xA3, multiplicand=0x15, start pulses exactly once, one cycle after the 4th accept, start_t=0. Then productDone=1 after 3 cycles -> in_ready returns to 1.
- Taint propagation: in_data_t=0x8 on word 2 only -> multiplier_t=0x80, multiplicand_t=0x00. With in_valid_t=1 on one beat -> start_t=1 during START. After WAIT exits, the next run has start_t=0.
- Stale done: productDone held at 1 throughout -> start, then ARM, then WAIT exits on the next cycle, i.e. busy high for exactly 3 cycles. No words are accepted while busy.
- Backpressure: in_valid=1 during WAIT with data 0xF -> in_ready=0, operands unchanged; that word is accepted in the first LOAD_MR cycle after done.
- Mid-operation reset: rst asserted after 3 of 4 words -> next cycle shows state LOAD_MR, cnt=0, operands and taints 0, start=0. The following 4 words give a correct fresh load.
- Tainted done: productDone_t=1 in WAIT -> ctrl_taint is cleared on exit (clear has priority). The next start_t=0 when all input taints are 0.

Source files
------------

// File: rtl/mul_loader_pkg.sv
// Shared encodings for the operand loader: FSM state codes and the word-counter width helper.
package mul_loader_pkg;

  localparam logic [2:0] LOAD_MR = 3'd0;
  localparam logic [2:0] LOAD_MD = 3'd1;
  localparam logic [2:0] START   = 3'd2;
  localparam logic [2:0] ARM     = 3'd3;
  localparam logic [2:0] WAIT    = 3'd4;

  // Counter needs at least one bit even when a single beat fills the operand.
  function automatic int cnt_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/mul_operand_slicereg_tainttrack.sv
// Word-sliced operand register with a parallel bitwise taint register.
module mul_operand_slicereg_tainttrack
  import mul_loader_pkg::*;
#(
  parameter int WIDTH  = 4096,
  parameter int BUS_W  = 64,
  localparam int NWORDS = WIDTH / BUS_W,
  localparam int CNT_W  = cnt_width(NWORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [CNT_W-1:0] idx,
  input  logic [BUS_W-1:0] word,
  input  logic [BUS_W-1:0] word_t,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_t
);

  // One independent register pair per word slot; only the addressed slot loads.
  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_slice
    logic [BUS_W-1:0] val_reg;
    logic [BUS_W-1:0] taint_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        val_reg   <= '0;
        taint_reg <= '0;
      end else if (we && (idx == CNT_W'(gi))) begin
        val_reg   <= word;
        taint_reg <= word_t;
      end
    end

    assign value[gi*BUS_W +: BUS_W]   = val_reg;
    assign value_t[gi*BUS_W +: BUS_W] = taint_reg;
  end

endmodule

// File: rtl/mul_operand_loader_tainttrack.sv
// Assembles multiplier/multiplicand from a narrow taint-tracked word stream and
// hands them to the multiplier with a start pulse, then waits for productDone.
module mul_operand_loader_tainttrack
  import mul_loader_pkg::*;
#(
  parameter int WIDTH = 4096,
  parameter int BUS_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_valid_t,
  input  logic [BUS_W-1:0] in_data,
  input  logic [BUS_W-1:0] in_data_t,
  output logic             in_ready,
  output logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] multiplier_t,
  output logic [WIDTH-1:0] multiplicand,
  output logic [WIDTH-1:0] multiplicand_t,
  output logic             start,
  output logic             start_t,
  input  logic             productDone,
  input  logic             productDone_t,
  output logic             busy
);

  localparam int NWORDS = WIDTH / BUS_W;
  localparam int CNT_W  = cnt_width(NWORDS);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ctrl_taint_reg, ctrl_taint_next;

  logic accept;
  logic last_word;
  logic we_mr;
  logic we_md;
  logic taint_set;
  logic taint_clr;

  assign accept    = in_valid && in_ready;
  assign last_word = (cnt_reg == CNT_W'(NWORDS - 1));
  assign we_mr     = accept && (state_reg == LOAD_MR);
  assign we_md     = accept && (state_reg == LOAD_MD);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= LOAD_MR;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD_MR: if (accept && last_word) state_next = LOAD_MD;
      LOAD_MD: if (accept && last_word) state_next = START;
      START:   state_next = ARM;
      // A done level left over from the previous product is deliberately not looked at here.
      ARM:     state_next = WAIT;
      WAIT:    if (productDone) state_next = LOAD_MR;
      default: state_next = LOAD_MR;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == LOAD_MR) || (state_reg == LOAD_MD);
    busy     = (state_reg == START) || (state_reg == ARM) || (state_reg == WAIT);
    start    = (state_reg == START) && !rst;
    start_t  = start && ctrl_taint_reg;
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (accept) cnt_next = last_word ? '0 : cnt_reg + CNT_W'(1);
  end

  // Valid-taint counts whenever the loader is listening, even without a handshake.
  assign taint_set = (in_ready && in_valid_t) ||
                     (((state_reg == ARM) || (state_reg == WAIT)) && productDone_t);
  assign taint_clr = (state_reg == WAIT) && productDone;

  always_comb begin
    ctrl_taint_next = ctrl_taint_reg;
    if (taint_clr)      ctrl_taint_next = 1'b0;
    else if (taint_set) ctrl_taint_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      ctrl_taint_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      ctrl_taint_reg <= ctrl_taint_next;
    end
  end

  mul_operand_slicereg_tainttrack #(.WIDTH(WIDTH), .BUS_W(BUS_W)) u_mr (
    .clk     (clk),
    .rst     (rst),
    .we      (we_mr),
    .idx     (cnt_reg),
    .word    (in_data),
    .word_t  (in_data_t),
    .value   (multiplier),
    .value_t (multiplier_t)
  );

  mul_operand_slicereg_tainttrack #(.WIDTH(WIDTH), .BUS_W(BUS_W)) u_md (
    .clk     (clk),
    .rst     (rst),
    .we      (we_md),
    .idx     (cnt_reg),
    .word    (in_data),
    .word_t  (in_data_t),
    .value   (multiplicand),
    .value_t (multiplicand_t)
  );

endmodule

// File: tb/tb_mul_operand_loader_tainttrack.sv
// Self-checking bench for the operand loader at WIDTH=8, BUS_W=4 (two beats per operand).
module tb_mul_operand_loader_tainttrack;

  localparam int WIDTH = 8;
  localparam int BUS_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_valid_t;
  logic [BUS_W-1:0] in_data, in_data_t;
  logic             in_ready;
  logic [WIDTH-1:0] multiplier, multiplier_t, multiplicand, multiplicand_t;
  logic             start, start_t;
  logic             productDone, productDone_t;
  logic             busy;

  always #5 clk = ~clk;

  mul_operand_loader_tainttrack #(.WIDTH(WIDTH), .BUS_W(BUS_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_valid_t     (in_valid_t),
    .in_data        (in_data),
    .in_data_t      (in_data_t),
    .in_ready       (in_ready),
    .multiplier     (multiplier),
    .multiplier_t   (multiplier_t),
    .multiplicand   (multiplicand),
    .multiplicand_t (multiplicand_t),
    .start          (start),
    .start_t        (start_t),
    .productDone    (productDone),
    .productDone_t  (productDone_t),
    .busy           (busy)
  );

  typedef struct {
    logic [7:0] mr, mr_t, md, md_t;
    logic [3:0] vt;        // in_valid_t per beat
    bit         idle_t;    // one idle cycle with in_valid=0, in_valid_t=1 before loading
    bit         stale;     // productDone held high during the whole load
    int         dly;       // cycles after START before productDone is raised
    bit         done_t;
    bit         exp_st;
    int         exp_busy;
  } vec_t;

  typedef struct {
    logic [7:0] mr, mr_t, md, md_t;
    logic       st;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_starts = 0;
  int   waits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timeout, got no event expected event", name);
  endtask

  // Advance one cycle and sample just after the edge; a start pulse pops the scoreboard.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (start) begin
      n_starts++;
      if (sb.size() == 0) begin
        bound_fail("unexpected_start");
      end else begin
        e = sb.pop_front();
        chk("multiplier", 32'(multiplier), 32'(e.mr));
        chk("multiplier_t", 32'(multiplier_t), 32'(e.mr_t));
        chk("multiplicand", 32'(multiplicand), 32'(e.md));
        chk("multiplicand_t", 32'(multiplicand_t), 32'(e.md_t));
        chk("start_t", 32'(start_t), 32'(e.st));
      end
    end
  endtask

  task automatic send_word(input logic [3:0] d, input logic [3:0] t, input logic vt,
                           output int tries);
    bit got;
    got = 0;
    tries = 0;
    in_valid = 1'b1; in_data = d; in_data_t = t; in_valid_t = vt;
    for (int k = 0; k < 50 && !got; k++) begin
      tries++;
      if (in_ready) got = 1;
      cycle();
    end
    in_valid = 1'b0; in_valid_t = 1'b0; in_data_t = '0;
    if (!got) bound_fail("accept_wait");
  endtask

  // Called in the START cycle; counts busy cycles until the loader listens again.
  task automatic finish_op(input int dly, input bit dt, input int exp_busy,
                           input bit hold, input logic [7:0] hold_mr);
    int  n;
    bit  back;
    n = 0;
    back = 0;
    if (hold) begin
      in_valid = 1'b1; in_data = 4'hF; in_data_t = '0; in_valid_t = 1'b0;
    end
    for (int k = 0; k < 40 && !back; k++) begin
      if (k == dly) begin
        productDone = 1'b1; productDone_t = dt;
      end
      if (in_ready) begin
        back = 1;
      end else begin
        if (busy) n++;
        if (hold) chk("bp_mr_stable", 32'(multiplier), 32'(hold_mr));
        cycle();
      end
    end
    productDone = 1'b0; productDone_t = 1'b0;
    if (!back) bound_fail("done_wait");
    chk("busy_cycles", 32'(n), 32'(exp_busy));
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input vec_t v);
    exp_t e;
    int   t;
    logic [3:0] w, wt;
    e.mr = v.mr; e.mr_t = v.mr_t; e.md = v.md; e.md_t = v.md_t; e.st = v.exp_st;
    sb.push_back(e);
    productDone = v.stale; productDone_t = 1'b0;
    if (v.idle_t) begin
      in_valid = 1'b0; in_valid_t = 1'b1;
      cycle();
      in_valid_t = 1'b0;
    end
    for (int b = 0; b < 4; b++) begin
      w  = (b < 2) ? v.mr[b*4 +: 4]   : v.md[(b-2)*4 +: 4];
      wt = (b < 2) ? v.mr_t[b*4 +: 4] : v.md_t[(b-2)*4 +: 4];
      send_word(w, wt, v.vt[b], t);
    end
    chk("start_after_last", 32'(start), 32'd1);
    finish_op(v.dly, v.done_t, v.exp_busy, 1'b0, 8'h00);
  endtask

  initial begin
    vec_t bp;
    int   t;
    //          mr     mr_t   md     md_t   vt       idle stale dly dt st busy
    vecs[0] = '{8'hA3, 8'h00, 8'h15, 8'h00, 4'b0000, 0,   0,    3,  0, 0, 4};
    vecs[1] = '{8'hA3, 8'h80, 8'h15, 8'h00, 4'b0010, 0,   0,    0,  0, 1, 3};
    vecs[2] = '{8'h5C, 8'h00, 8'hE7, 8'h0F, 4'b0000, 0,   0,    0,  1, 0, 3};
    vecs[3] = '{8'h00, 8'h00, 8'hFF, 8'h00, 4'b0000, 0,   0,    5,  0, 0, 6};
    vecs[4] = '{8'h12, 8'h00, 8'h34, 8'h00, 4'b0000, 1,   0,    2,  0, 1, 3};
    vecs[5] = '{8'hFF, 8'hFF, 8'h9D, 8'h42, 4'b1000, 0,   0,    1,  0, 1, 3};
    vecs[6] = '{8'h6B, 8'h00, 8'hC4, 8'h00, 4'b0000, 0,   1,    0,  0, 0, 3};

    rst = 1'b1;
    in_valid = 1'b0; in_valid_t = 1'b0; in_data = '0; in_data_t = '0;
    productDone = 1'b0; productDone_t = 1'b0;
    cycle();
    chk("start_in_reset", 32'(start), 32'd0);
    cycle();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_multiplier", 32'(multiplier), 32'd0);
    chk("rst_multiplicand_t", 32'(multiplicand_t), 32'd0);
    chk("rst_start_t", 32'(start_t), 32'd0);

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    // Backpressure: a word held during WAIT must wait for the next LOAD_MR.
    bp = '{8'h21, 8'h00, 8'h43, 8'h00, 4'b0000, 0, 0, 0, 0, 0, 3};
    sb.push_back('{8'h21, 8'h00, 8'h43, 8'h00, 1'b0});
    send_word(4'h1, 4'h0, 1'b0, t);
    send_word(4'h2, 4'h0, 1'b0, t);
    send_word(4'h3, 4'h0, 1'b0, t);
    send_word(4'h4, 4'h0, 1'b0, t);
    finish_op(1, 1'b0, bp.exp_busy, 1'b1, 8'h21);
    sb.push_back('{8'h6F, 8'h00, 8'h87, 8'h00, 1'b0});
    send_word(4'hF, 4'h0, 1'b0, t);
    chk("bp_first_try_accept", 32'(t), 32'd1);
    send_word(4'h6, 4'h0, 1'b0, t);
    send_word(4'h7, 4'h0, 1'b0, t);
    send_word(4'h8, 4'h0, 1'b0, t);
    finish_op(0, 1'b0, 3, 1'b0, 8'h00);

    // Mid-operation reset after three of four words, with a tainted beat in flight.
    send_word(4'hB, 4'h3, 1'b1, t);
    send_word(4'h9, 4'h0, 1'b0, t);
    send_word(4'hC, 4'h5, 1'b0, t);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_multiplier", 32'(multiplier), 32'd0);
    chk("mrst_multiplier_t", 32'(multiplier_t), 32'd0);
    chk("mrst_multiplicand", 32'(multiplicand), 32'd0);
    chk("mrst_multiplicand_t", 32'(multiplicand_t), 32'd0);
    chk("mrst_start", 32'(start), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    run_op(vecs[0]);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("start_pulses", 32'(n_starts), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
